vproc_tb_mem: RTL and testbench

Multi-port, parametrised memory model for the Vicuna simulation environment. It replaces the single-port inline memory of the system testbench. It serves `PORTS` independent request/response channels, for example separate instruction, scalar-data and vector-data ports, from one shared word array. Each channel has a configurable fixed response latency, a grant handshake, out-of-range error reporting and program-end detection. As a build option, it can throttle grants pseudo-randomly to stress the core's memory interfaces.

---
 rtl/vproc_tb_mem_pkg.sv | 39 +++
 rtl/vproc_tb_mem_lfsr.sv | 33 +++
 rtl/vproc_tb_mem.sv | 162 ++++++++++++++++
 tb/tb_vproc_tb_mem.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vproc_tb_mem_pkg.sv
// ============================================================================
// vproc_tb_mem_pkg : shared types, constants and helpers for vproc_tb_mem
// Revision: 1.0
// ============================================================================
`default_nettype none

package vproc_tb_mem_pkg;

    localparam int LFSR_W = 16;
    // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Widest supported word; narrower ports use the low MEM_W bits
    localparam int RSP_DATA_W = 512;

    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [RSP_DATA_W-1:0] rdata;
    } mem_rsp_t;

    function automatic bit mem_params_ok(input int ports, input int mem_w,
                                         input int mem_sz, input int latency);
        return (ports >= 1) && (mem_w >= 32) && (mem_w % 32 == 0) &&
               (mem_w <= RSP_DATA_W) && (mem_sz > 0) &&
               ((mem_sz & (mem_sz - 1)) == 0) && (mem_sz >= 2 * (mem_w / 8)) &&
               (latency >= 1);
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base,
                                                    input int port);
        logic [LFSR_W-1:0] s;
        s = base ^ LFSR_W'(port);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vproc_tb_mem_lfsr.sv
// ============================================================================
// vproc_tb_mem_lfsr : 16-bit Galois LFSR, advances every cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module vproc_tb_mem_lfsr
    import vproc_tb_mem_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else if (r_state[0]) begin
            r_state <= (r_state >> 1) ^ LFSR_TAPS;
        end else begin
            r_state <= r_state >> 1;
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/vproc_tb_mem.sv
// ============================================================================
// vproc_tb_mem : multi-port fixed-latency memory model with program-end detect.
// Build option VPROC_TB_MEM_RANDSTALL_EN enables pseudo-random grant stalls.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vproc_tb_mem
    import vproc_tb_mem_pkg::*;
#(
    parameter int          PORTS     = 2,
    parameter int          MEM_W     = 32,
    parameter int          MEM_SZ    = 262144,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] END_ADDR  = 32'h0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [PORTS-1:0]             req_i,
    output logic [PORTS-1:0]             gnt_o,
    input  logic [PORTS-1:0][31:0]       addr_i,
    input  logic [PORTS-1:0]             we_i,
    input  logic [PORTS-1:0][MEM_W/8-1:0] be_i,
    input  logic [PORTS-1:0][MEM_W-1:0]  wdata_i,
    output logic [PORTS-1:0]             rvalid_o,
    output logic [PORTS-1:0][MEM_W-1:0]  rdata_o,
    output logic [PORTS-1:0]             err_o,
    output logic                         prog_end_o
);

    localparam int BYTES  = MEM_W / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int ADDR_W = $clog2(MEM_SZ);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int WORDS  = MEM_SZ / BYTES;

    if (!mem_params_ok(PORTS, MEM_W, MEM_SZ, LATENCY)) begin : g_param_err
        $error("vproc_tb_mem: invalid parameter combination");
    end

    // Contents are preloaded by the surrounding environment; deliberately not reset
    logic [MEM_W-1:0] mem [WORDS];

    function automatic logic [MEM_W-1:0] x_to_zero(input logic [MEM_W-1:0] w);
        return (^w === 1'bx) ? '0 : w;
    endfunction

    logic                              r_ready;
    logic [PORTS-1:0]                  w_acc;
    logic [PORTS-1:0]                  w_oor;
    logic [PORTS-1:0][IDX_W-1:0]       w_idx;
    logic [PORTS-1:0][OFF_W-1:0]       w_addr_unused;
    mem_rsp_t [PORTS-1:0]              w_rsp;
    mem_rsp_t                          r_pipe [PORTS][LATENCY];
    logic                              r_armed;
    logic                              r_prog_end;

    // Grant depends only on registered state so it never combinationally follows req_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

`ifdef VPROC_TB_MEM_RANDSTALL_EN
    logic [PORTS-1:0][LFSR_W-1:0] w_lfsr;

    for (genvar p = 0; p < PORTS; p++) begin : g_lfsr
        vproc_tb_mem_lfsr #(
            .SEED (lfsr_seed(LFSR_SEED, p))
        ) u_lfsr (
            .clk   (clk_i),
            .rst   (rst_i),
            .state (w_lfsr[p])
        );
        assign gnt_o[p] = r_ready & ~w_lfsr[p][0] & ~w_lfsr[p][1];
    end
`else
    localparam logic [15:0] c_seed_unused = LFSR_SEED;
    assign gnt_o = {PORTS{r_ready}};
`endif

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            w_acc[p]         = req_i[p] & gnt_o[p];
            w_idx[p]         = addr_i[p][ADDR_W-1:OFF_W];
            w_addr_unused[p] = addr_i[p][OFF_W-1:0];
            w_oor[p]         = (addr_i[p][31:ADDR_W] != '0);
            w_rsp[p]         = '0;
            if (w_acc[p]) begin
                w_rsp[p].valid = 1'b1;
                w_rsp[p].err   = w_oor[p];
                if (!w_oor[p]) begin
                    w_rsp[p].rdata[MEM_W-1:0] = x_to_zero(mem[w_idx[p]]);
                end
            end
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins on a byte clash
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < PORTS; p++) begin
            if (w_acc[p] && we_i[p] && !w_oor[p]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (be_i[p][b]) begin
                        mem[w_idx[p]][b*8 +: 8] <= wdata_i[p][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < PORTS; p++) begin
                for (int s = 0; s < LATENCY; s++) begin
                    r_pipe[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                r_pipe[p][0] <= w_rsp[p];
                for (int s = 1; s < LATENCY; s++) begin
                    r_pipe[p][s] <= r_pipe[p][s-1];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            rvalid_o[p] = r_pipe[p][LATENCY-1].valid;
            err_o[p]    = r_pipe[p][LATENCY-1].err;
            rdata_o[p]  = r_pipe[p][LATENCY-1].rdata[MEM_W-1:0];
        end
    end

    // Program end only counts once the core has fetched something other than END_ADDR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_armed    <= 1'b0;
            r_prog_end <= 1'b0;
        end else begin
            r_prog_end <= 1'b0;
            if (w_acc[0]) begin
                if (addr_i[0] == END_ADDR) begin
                    r_prog_end <= r_armed;
                end else begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    assign prog_end_o = r_prog_end;

endmodule

`default_nettype wire

// File: tb/tb_vproc_tb_mem.sv
// ============================================================================
// tb_vproc_tb_mem : directed self-checking bench, LATENCY=1 and LATENCY=4 instances
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vproc_tb_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic             rst1, pe1;
    logic [1:0]       req1, gnt1, we1, rv1, err1;
    logic [1:0][31:0] addr1, wd1, rd1;
    logic [1:0][3:0]  be1;

    logic             rst4, pe4;
    logic [1:0]       req4, gnt4, we4, rv4, err4;
    logic [1:0][31:0] addr4, wd4, rd4;
    logic [1:0][3:0]  be4;

    vproc_tb_mem #(
        .PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(1),
        .END_ADDR(32'h0000_0FFC), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst1), .req_i(req1), .gnt_o(gnt1), .addr_i(addr1),
        .we_i(we1), .be_i(be1), .wdata_i(wd1), .rvalid_o(rv1), .rdata_o(rd1),
        .err_o(err1), .prog_end_o(pe1)
    );

    vproc_tb_mem #(
        .PORTS(2), .MEM_W(32), .MEM_SZ(262144), .LATENCY(4),
        .END_ADDR(32'h0), .LFSR_SEED(16'hACE1)
    ) dut4 (
        .clk_i(clk), .rst_i(rst4), .req_i(req4), .gnt_o(gnt4), .addr_i(addr4),
        .we_i(we4), .be_i(be4), .wdata_i(wd4), .rvalid_o(rv4), .rdata_o(rd4),
        .err_o(err4), .prog_end_o(pe4)
    );

    task automatic drive(input int d, input int p, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (d == 1) begin
            req1[p] = 1'b1; we1[p] = we; addr1[p] = a; be1[p] = be; wd1[p] = wd;
        end else begin
            req4[p] = 1'b1; we4[p] = we; addr4[p] = a; be4[p] = be; wd4[p] = wd;
        end
    endtask

    task automatic idle();
        req1 = '0; we1 = '0; req4 = '0; we4 = '0;
    endtask

    task automatic test_reset();
        int n;
        rst1 = 1'b1; rst4 = 1'b1; idle();
        repeat (3) @(negedge clk);
        checks++; if ({gnt1, gnt4} !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b want 0000", {gnt1, gnt4}); end
        checks++; if ({rv1, rv4} !== 4'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0000", {rv1, rv4}); end
        checks++; if ({rd1, rd4} !== 128'b0) begin errors++; $display("FAIL reset_rdata got %h want 0", {rd1, rd4}); end
        checks++; if ({err1, err4, pe1, pe4} !== 6'b0) begin errors++; $display("FAIL reset_err_pe got %b want 000000", {err1, err4, pe1, pe4}); end
        rst1 = 1'b0; rst4 = 1'b0;
        n = 0;
        while ((gnt1 !== 2'b11 || gnt4 !== 2'b11) && n < 8) begin @(negedge clk); n++; end
        checks++; if (gnt1 !== 2'b11) begin errors++; $display("FAIL grant_after_reset1 got %b want 11", gnt1); end
        checks++; if (gnt4 !== 2'b11) begin errors++; $display("FAIL grant_after_reset4 got %b want 11", gnt4); end
    endtask

    task automatic test_write_read();
        drive(1, 1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk); idle();
        checks++; if ({rv1, err1} !== 4'b1000) begin errors++; $display("FAIL wr_resp rvalid/err got %b want 1000", {rv1, err1}); end
        drive(1, 0, 1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (rv1 !== 2'b01) begin errors++; $display("FAIL rd_latency1 rvalid got %b want 01", rv1); end
        checks++; if (rd1[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", rd1[0]); end
        checks++; if (err1[0] !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", err1[0]); end
        @(negedge clk);
        checks++; if (rv1 !== 2'b00) begin errors++; $display("FAIL rd_single_resp rvalid got %b want 00", rv1); end
    endtask

    task automatic test_same_cycle();
        drive(1, 1, 1'b1, 32'h200, 4'hF, 32'h11);
        @(negedge clk); idle();
        drive(1, 0, 1'b0, 32'h200, 4'h0, 32'h0);
        drive(1, 1, 1'b1, 32'h200, 4'hF, 32'h22);
        @(negedge clk); idle();
        checks++; if (rd1[0] !== 32'h11) begin errors++; $display("FAIL rbw_read got %h want 11", rd1[0]); end
        checks++; if (rd1[1] !== 32'h11) begin errors++; $display("FAIL rbw_write_resp got %h want 11", rd1[1]); end
        drive(1, 0, 1'b0, 32'h200, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (rd1[0] !== 32'h22) begin errors++; $display("FAIL rbw_after got %h want 22", rd1[0]); end
    endtask

    task automatic test_port_priority();
        drive(1, 0, 1'b1, 32'h300, 4'hF, 32'h12345678);
        drive(1, 1, 1'b1, 32'h300, 4'hF, 32'h9ABCDEF0);
        @(negedge clk); idle();
        drive(1, 0, 1'b0, 32'h300, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (rd1[0] !== 32'h9ABCDEF0) begin errors++; $display("FAIL port_priority got %h want 9abcdef0", rd1[0]); end
    endtask

    task automatic test_byte_enable();
        drive(1, 0, 1'b1, 32'h0, 4'hF, 32'h0);
        @(negedge clk); idle();
        drive(1, 0, 1'b1, 32'h0, 4'b0101, 32'hAABBCCDD);
        @(negedge clk); idle();
        checks++; if (rd1[0] !== 32'h0) begin errors++; $display("FAIL be_write_resp got %h want 0", rd1[0]); end
        drive(1, 0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (rd1[0] !== 32'h00BB00DD) begin errors++; $display("FAIL be_word got %h want 00bb00dd", rd1[0]); end
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 1'b1, 32'h0004_0000, 4'hF, 32'hFFFFFFFF);
        @(negedge clk); idle();
        checks++; if ({rv1[1], err1[1]} !== 2'b11) begin errors++; $display("FAIL oor_wr rvalid/err got %b want 11", {rv1[1], err1[1]}); end
        checks++; if (rd1[1] !== 32'h0) begin errors++; $display("FAIL oor_wr_data got %h want 0", rd1[1]); end
        drive(1, 0, 1'b0, 32'h0004_0000, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if ({rv1[0], err1[0], rd1[0]} !== {2'b11, 32'h0}) begin errors++; $display("FAIL oor_rd got v/e=%b%b data %h want 11 0", rv1[0], err1[0], rd1[0]); end
        drive(1, 0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (rd1[0] !== 32'h00BB00DD) begin errors++; $display("FAIL oor_mem_unchanged got %h want 00bb00dd", rd1[0]); end
        drive(1, 0, 1'b0, 32'h0003_FFFC, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if ({rv1[0], err1[0]} !== 2'b10) begin errors++; $display("FAIL top_word_in_range got %b want 10", {rv1[0], err1[0]}); end
    endtask

    task automatic test_back_to_back();
        logic pe_seen;
        drive(4, 1, 1'b1, 32'h0, 4'hF, 32'd1); @(negedge clk);
        drive(4, 1, 1'b1, 32'h4, 4'hF, 32'd2); @(negedge clk);
        drive(4, 1, 1'b1, 32'h8, 4'hF, 32'd3); @(negedge clk);
        idle();
        repeat (5) @(negedge clk);
        pe_seen = 1'b0;
        drive(4, 0, 1'b0, 32'h0, 4'h0, 32'h0); @(negedge clk); pe_seen |= pe4;
        drive(4, 0, 1'b0, 32'h4, 4'h0, 32'h0); @(negedge clk); pe_seen |= pe4;
        drive(4, 0, 1'b0, 32'h8, 4'h0, 32'h0); @(negedge clk); pe_seen |= pe4;
        idle();
        checks++; if (rv4[0] !== 1'b0) begin errors++; $display("FAIL b2b_early rvalid got %b want 0", rv4[0]); end
        @(negedge clk); pe_seen |= pe4;
        checks++; if ({rv4[0], rd4[0]} !== {1'b1, 32'd1}) begin errors++; $display("FAIL b2b_first got v=%b d=%h want 1 1", rv4[0], rd4[0]); end
        @(negedge clk); pe_seen |= pe4;
        checks++; if ({rv4[0], rd4[0]} !== {1'b1, 32'd2}) begin errors++; $display("FAIL b2b_second got v=%b d=%h want 1 2", rv4[0], rd4[0]); end
        @(negedge clk); pe_seen |= pe4;
        checks++; if ({rv4[0], rd4[0]} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_third got v=%b d=%h want 1 3", rv4[0], rd4[0]); end
        @(negedge clk); pe_seen |= pe4;
        checks++; if (rv4[0] !== 1'b0) begin errors++; $display("FAIL b2b_tail rvalid got %b want 0", rv4[0]); end
        checks++; if (pe_seen !== 1'b0) begin errors++; $display("FAIL prog_end_unarmed got %b want 0", pe_seen); end
    endtask

    task automatic test_reset_midflight();
        logic rv_seen;
        int   n;
        checks++; if (gnt4[0] !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %b want 1", gnt4[0]); end
        drive(4, 0, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk); idle();
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        rv_seen = 1'b0;
        repeat (8) begin @(negedge clk); rv_seen |= |rv4; end
        checks++; if (rv_seen !== 1'b0) begin errors++; $display("FAIL midrst_dropped rvalid_seen got %b want 0", rv_seen); end
        n = 0;
        while (gnt4[0] !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (gnt4[0] !== 1'b1) begin errors++; $display("FAIL midrst_regrant got %b want 1", gnt4[0]); end
    endtask

    task automatic test_prog_end();
        drive(4, 0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (pe4 !== 1'b0) begin errors++; $display("FAIL pe_disarmed_by_reset got %b want 0", pe4); end
        drive(4, 0, 1'b0, 32'h80, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (pe4 !== 1'b0) begin errors++; $display("FAIL pe_non_end got %b want 0", pe4); end
        drive(4, 0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk); idle();
        checks++; if (pe4 !== 1'b1) begin errors++; $display("FAIL pe_pulse got %b want 1", pe4); end
        @(negedge clk);
        checks++; if (pe4 !== 1'b0) begin errors++; $display("FAIL pe_one_cycle got %b want 0", pe4); end
        checks++; if (pe1 !== 1'b0) begin errors++; $display("FAIL pe_other_instance got %b want 0", pe1); end
    endtask

    initial begin
        rst1 = 1'b1; rst4 = 1'b1;
        req1 = '0; we1 = '0; addr1 = '0; be1 = '0; wd1 = '0;
        req4 = '0; we4 = '0; addr4 = '0; be4 = '0; wd4 = '0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_port_priority();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        test_prog_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
